// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin FIFO arbiter family.
//   arb_state_e : IDLE (no grant held) / BUSY (one-hot grant held)
//   STATS_W     : width of the optional transfer/stall statistics counters
//   clog2       : constant-evaluable ceil(log2) used to size pointers/counters
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

  // ceil(log2(value)); returns 0 for value <= 1, so callers clamp to >= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_mux.sv
// ---------------------------------------------------------------------------
// onehot_mux
// AND-OR multiplexer selecting one WIDTH-bit slice of a packed bus with a
// one-hot select. An all-zero select yields zero.
// Ports:
//   sel    in  CHANNELS        one-hot (or zero) select
//   i_data in  CHANNELS*WIDTH  packed inputs, slice i at [(i+1)*WIDTH-1:i*WIDTH]
//   o_data out WIDTH           selected slice
// ---------------------------------------------------------------------------
module onehot_mux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]          o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      o_data = o_data | (i_data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Rotating-priority scan: returns the first requester found scanning
// ptr, ptr+1, ... wrapping modulo CHANNELS, as a one-hot vector.
// Zero when no request is present. Purely combinational.
// Ports:
//   req    in  CHANNELS  request vector
//   ptr    in  PTR_W     highest-priority index this cycle
//   onehot out CHANNELS  selected requester
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int PTR_W   = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CHANNELS-1:0] onehot
);

  int   idx;
  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// rr_fifo_arbiter
// Shares one downstream port between CHANNELS FIFO read ports. A registered
// one-hot grant is held for up to MAX_BURST back-to-back transfers, then the
// priority pointer moves past the granted channel and a new grant is issued
// in the same cycle, so there is no bubble between grants.
// Optional build macro: ARB_STATS_EN adds xfer_cnt / stall_cnt outputs.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req       per-channel FIFO not-empty
//   i_data    packed FIFO read data, channel i at [(i+1)*WIDTH-1:i*WIDTH]
//   pop       one-hot FIFO read strobe (combinational)
//   grant     registered one-hot (or zero) grant
//   o_valid   output data valid (combinational)
//   o_ready   downstream accept
//   o_data    data of the granted channel
//   xfer_cnt  (ARB_STATS_EN) wrapping count of accepted transfers
//   stall_cnt (ARB_STATS_EN) saturating count of backpressured cycles
// ---------------------------------------------------------------------------
module rr_fifo_arbiter
  import arb_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]       pop,
  output logic [CHANNELS-1:0]       grant,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [WIDTH-1:0]          o_data
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]        xfer_cnt,
  output logic [STATS_W-1:0]        stall_cnt
`endif
);

  localparam int PTR_W = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS);
  localparam int CNT_W = (clog2(MAX_BURST) < 1) ? 1 : clog2(MAX_BURST);

  arb_state_e          state, state_next;
  logic [CHANNELS-1:0] grant_next;
  logic [PTR_W-1:0]    ptr, ptr_next, rel_ptr, pick_ptr, grant_idx;
  logic [CNT_W-1:0]    burst_cnt, burst_cnt_next;
  logic [CHANNELS-1:0] picked;
  logic                xfer, release_grant;

  // Handshake: only a granted channel that still has data can present or pop.
  assign o_valid = |(grant & req);
  assign pop     = grant & req & {CHANNELS{o_ready}};
  assign xfer    = o_valid & o_ready;

  // Index of the granted channel and the pointer just past it.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign rel_ptr = (grant_idx == PTR_W'(CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);

  // A single scanner serves both the initial grant from IDLE and the
  // same-cycle re-grant on release (which scans from the advanced pointer).
  assign pick_ptr = (state == ARB_BUSY) ? rel_ptr : ptr;

  rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (picked)
  );

  onehot_mux #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) u_mux (
    .sel    (grant),
    .i_data (i_data),
    .o_data (o_data)
  );

  // Release on a finished burst or when the granted FIFO no longer requests;
  // the latter also covers a request dropping while stalled, so no lockup.
  assign release_grant = (xfer && (burst_cnt == CNT_W'(MAX_BURST - 1))) || !o_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      ptr       <= ptr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant;
    ptr_next       = ptr;
    burst_cnt_next = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_next     = picked;
          burst_cnt_next = '0;
          state_next     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (release_grant) begin
          ptr_next       = rel_ptr;
          grant_next     = picked;
          burst_cnt_next = '0;
          state_next     = (|picked) ? ARB_BUSY : ARB_IDLE;
        end else if (xfer) begin
          burst_cnt_next = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next     = ARB_IDLE;
        grant_next     = '0;
        ptr_next       = '0;
        burst_cnt_next = '0;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Transfer count wraps; stall count saturates so long stalls stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + STATS_W'(1);
      if (o_valid && !o_ready && (stall_cnt != {STATS_W{1'b1}}))
        stall_cnt <= stall_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_fifo_arbiter
// Directed bench for rr_fifo_arbiter (CHANNELS=4, WIDTH=8, MAX_BURST=2).
// Inputs change on the falling edge and outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_rr_fifo_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] i_data;
  logic [3:0]  pop;
  logic [3:0]  grant;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_data;
`ifdef ARB_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  rr_fifo_arbiter #(.CHANNELS(4), .WIDTH(8), .MAX_BURST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .i_data    (i_data),
    .pop       (pop),
    .grant     (grant),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data)
`ifdef ARB_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [3:0] pop;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[11];

  // Drive one cycle's inputs just after the falling edge and let them settle.
  task automatic apply_stimulus(input logic r, input logic [3:0] rq, input logic rdy);
    @(negedge clk);
    rst     = r;
    req     = rq;
    o_ready = rdy;
    #1;
  endtask

  task automatic check_field(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] eg, input logic [3:0] ep,
                              input logic ev, input logic [7:0] ed);
    check_field({tag, " grant"},   16'(grant),   16'(eg));
    check_field({tag, " pop"},     16'(pop),     16'(ep));
    check_field({tag, " o_valid"}, 16'(o_valid), 16'(ev));
    check_field({tag, " o_data"},  16'(o_data),  16'(ed));
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 4'b0000, 1'b1);
    apply_stimulus(1'b1, 4'b0000, 1'b1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    req          = 4'b0000;
    o_ready      = 1'b1;
    i_data       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Reset with everyone requesting, then full rotation with bursts of two.
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA0};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hB1};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hB1};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hC2};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hC2};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'hD3};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'hD3};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA0};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].rdy);
      check_output($sformatf("rot%0d", i), vecs[i].grant, vecs[i].pop, vecs[i].valid, vecs[i].data);
    end

    // Sole requester ch2 with five entries: grant re-issued, no gaps.
    do_reset();
    apply_stimulus(1'b0, 4'b0100, 1'b1);
    check_output("solo idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 4'b0100, 1'b1);
      check_output($sformatf("solo pop%0d", i), 4'b0100, 4'b0100, 1'b1, 8'hC2);
    end
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("solo empty", 4'b0100, 4'b0000, 1'b0, 8'hC2);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("solo back idle", 4'b0000, 4'b0000, 1'b0, 8'h00);

    // Backpressure on ch1 for three cycles with ch2 also waiting.
    do_reset();
    apply_stimulus(1'b0, 4'b0110, 1'b0);
    check_output("bp idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 4'b0110, 1'b0);
      check_output($sformatf("bp stall%0d", i), 4'b0010, 4'b0000, 1'b1, 8'hB1);
    end
    apply_stimulus(1'b0, 4'b0110, 1'b1);
    check_output("bp first", 4'b0010, 4'b0010, 1'b1, 8'hB1);
    apply_stimulus(1'b0, 4'b0110, 1'b1);
    check_output("bp second", 4'b0010, 4'b0010, 1'b1, 8'hB1);
    apply_stimulus(1'b0, 4'b0110, 1'b1);
    check_output("bp rotate", 4'b0100, 4'b0100, 1'b1, 8'hC2);
`ifdef ARB_STATS_EN
    check_field("bp xfer_cnt",  xfer_cnt,  16'd2);
    check_field("bp stall_cnt", stall_cnt, 16'd3);
`endif

    // Early release: ch0 has one entry, ch1 takes over without a bubble.
    do_reset();
    apply_stimulus(1'b0, 4'b0011, 1'b1);
    check_output("early idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 4'b0011, 1'b1);
    check_output("early ch0", 4'b0001, 4'b0001, 1'b1, 8'hA0);
    apply_stimulus(1'b0, 4'b0010, 1'b1);
    check_output("early drop", 4'b0001, 4'b0000, 1'b0, 8'hA0);
    apply_stimulus(1'b0, 4'b0010, 1'b1);
    check_output("early ch1", 4'b0010, 4'b0010, 1'b1, 8'hB1);
    apply_stimulus(1'b0, 4'b0011, 1'b1);
    check_output("early ch1 b2", 4'b0010, 4'b0011 & 4'b0010, 1'b1, 8'hB1);
    apply_stimulus(1'b0, 4'b0011, 1'b1);
    check_output("early wrap ch0", 4'b0001, 4'b0001, 1'b1, 8'hA0);

    // Asynchronous reset in the middle of a ch2 burst.
    do_reset();
    apply_stimulus(1'b0, 4'b0100, 1'b1);
    apply_stimulus(1'b0, 4'b0100, 1'b1);
    check_output("mid burst", 4'b0100, 4'b0100, 1'b1, 8'hC2);
    #1 rst = 1'b1;
    #1;
    check_output("async rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
`ifdef ARB_STATS_EN
    check_field("rst xfer_cnt",  xfer_cnt,  16'd0);
    check_field("rst stall_cnt", stall_cnt, 16'd0);
`endif
    apply_stimulus(1'b0, 4'b1111, 1'b1);
    check_output("restart idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
    apply_stimulus(1'b0, 4'b1111, 1'b1);
    check_output("restart ch0", 4'b0001, 4'b0001, 1'b1, 8'hA0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_fifo_arbiter.md
Name: rr_fifo_arbiter

Overview:
Round-robin scheduler that shares one downstream output port between CHANNELS arbitrated FIFOs. It holds a registered one-hot grant, pops the granted FIFO on each accepted transfer, and steers that FIFO's data to the output through an onehot_mux instance. A grant is held for up to MAX_BURST back-to-back transfers, then rotates. Sits between the per-channel FIFO read ports and the shared consumer.

Parameters:
CHANNELS, 4, number of requesting FIFOs (>=2)
WIDTH, 8, data width per channel
MAX_BURST, 2, max consecutive transfers per grant (>=1; 1 = rotate every transfer)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  CHANNELS  per-channel FIFO not-empty
i_data  in  CHANNELS*WIDTH  packed FIFO read data, channel i at [(i+1)*WIDTH-1:i*WIDTH]
pop  out  CHANNELS  one-hot FIFO read strobe, combinational
grant  out  CHANNELS  registered one-hot (or zero) grant
o_valid  out  1  output data valid, combinational
o_ready  in  1  downstream accept
o_data  out  WIDTH  selected data, meaningful only when o_valid=1

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, ptr=0, burst_cnt=0; therefore o_valid=0, pop=0, o_data=0.
- State: IDLE (grant=0) / BUSY (grant one-hot). ptr width max(1,$clog2(CHANNELS)); burst_cnt width max(1,$clog2(MAX_BURST)).
- pick(req, ptr): first set bit scanning ptr, ptr+1, ..., wrapping modulo CHANNELS; zero if req=0.
- IDLE: if |req, grant<=pick(req,ptr), burst_cnt<=0, go BUSY. Latency req->grant is 1 cycle. Else stay.
- BUSY: o_valid = |(grant & req); pop = grant & req & {CHANNELS{o_ready}}; xfer = o_valid & o_ready.
- o_data = onehot_mux(grant, i_data); zero when grant=0.
- On xfer with burst_cnt < MAX_BURST-1: burst_cnt++, grant held.
- Release when (xfer & burst_cnt==MAX_BURST-1) or (grant & req)==0, meaning the granted FIFO emptied or dropped its request. On release: ptr <= index(grant)+1 mod CHANNELS; same cycle, grant <= pick(req, that new ptr), burst_cnt<=0. Stay BUSY if nonzero, else go IDLE. No bubble cycle between grants when other requesters are present.
- Sole requester: pick wraps back to the same channel, so the grant is re-issued and there is no gap in throughput.
- Backpressure (o_valid & !o_ready): grant, burst_cnt, ptr and o_data are held; pop=0.
- req of the granted channel dropping while stalled is a protocol violation. It is tolerated: the grant is released as above with no pop and no lockup.
- pop is never asserted for a non-granted channel and never more than one bit.
- Reset asserted mid-burst: immediate return to reset values; no pop is issued.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs xfer_cnt (out, 16) and stall_cnt (out, 16), both reset to 0.
  - xfer_cnt increments on each xfer and wraps at 16'hFFFF->0.
  - stall_cnt increments each cycle with o_valid & !o_ready and saturates at 16'hFFFF.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package arb_pkg:
  - state encoding localparams ARB_IDLE=1'b0, ARB_BUSY=1'b1
  - STATS_W=16
  - clog2 helper function
- Sub-modules:
  - existing onehot_mux (CHANNELS, WIDTH) instantiated for the data path
  - one natural new combinational sub-module rr_pick(req, ptr -> onehot) for the rotating priority scan; reusable by other arbiters.

Test Plan:
- Reset: rst=1 with req=4'b1111 -> grant=0, pop=0, o_valid=0, o_data=0; rst release -> grant=4'b0001 one cycle later.
- All requesting, o_ready=1, MAX_BURST=2, ptr=0 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; exactly one pop per cycle; no idle cycle.
- Only ch2 requests, 5 entries, o_ready=1 -> grant=4'b0100 continuously, 5 pops on consecutive cycles, then IDLE with grant=0 the cycle after req drops.
- Backpressure: grant=0010, o_ready=0 for 3 cycles -> pop=0, grant, o_data and burst_cnt held; first cycle o_ready=1 -> one pop to ch1, then a second transfer before rotation.
- Early release: req=4'b0011, ch0 holds 1 entry, MAX_BURST=2 -> one pop ch0, req[0] drops, next cycle grant=4'b0010, ptr=1.
- Mid-burst async reset: assert rst between clock edges during grant=0100 -> grant, pop and o_valid go 0 without waiting for a clock edge. After release, arbitration restarts at ch0. With ARB_STATS_EN, xfer_cnt and stall_cnt read 0.
